// File: rtl/alu_regfile_if.sv
// Decode-stage bus for alu_regfile: three read ports, one write port, ALU operands and results.
// Every path is zero-cycle combinational; there is no handshake and no backpressure.
interface alu_regfile_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3
);
  logic [AWIDTH-1:0] raddr_a;
  logic [DWIDTH-1:0] rdata_a;
  logic [AWIDTH-1:0] raddr_b;
  logic [DWIDTH-1:0] rdata_b;
  logic [AWIDTH-1:0] raddr_c;
  logic [DWIDTH-1:0] rdata_c;
  logic              we;
  logic [AWIDTH-1:0] waddr;
  logic [DWIDTH-1:0] wdata;
  logic [2:0]        alu_op;
  logic [DWIDTH-1:0] alu_a;
  logic [DWIDTH-1:0] alu_b;
  logic [DWIDTH-1:0] alu_result;
  logic [3:0]        alu_cc;

  modport master (
    output raddr_a, raddr_b, raddr_c, we, waddr, wdata, alu_op, alu_a, alu_b,
    input  rdata_a, rdata_b, rdata_c, alu_result, alu_cc
  );

  modport slave (
    input  raddr_a, raddr_b, raddr_c, we, waddr, wdata, alu_op, alu_a, alu_b,
    output rdata_a, rdata_b, rdata_c, alu_result, alu_cc
  );
endinterface

// File: rtl/alu_regfile.sv
// 8x16 register file (3 comb reads, 1 sync write, 1-cycle write latency) plus a comb 8-op ALU with {N,Z,C,V}.
// No backpressure. Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on reads.
module alu_regfile #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3
) (
  input logic         clk,
  input logic         rst,
  alu_regfile_if.slave bus
);
  localparam int NREG = 1 << AWIDTH;
  localparam int SHW  = $clog2(DWIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_LSL = 3'd5,
    OP_LSR = 3'd6,
    OP_MOV = 3'd7
  } alu_op_e;

  logic [DWIDTH-1:0] regs [NREG];

  // Reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  function automatic logic [DWIDTH-1:0] read_port(
    input logic [AWIDTH-1:0] addr,
    input logic              fwd_en,
    input logic [AWIDTH-1:0] fwd_addr,
    input logic [DWIDTH-1:0] fwd_data,
    input logic [DWIDTH-1:0] stored
  );
`ifdef REGFILE_BYPASS_EN
    if (fwd_en && (fwd_addr == addr)) begin
      return fwd_data;
    end
    return stored;
`else
    logic unused;
    unused = fwd_en ^ (^fwd_addr) ^ (^fwd_data) ^ (^addr);
    return stored;
`endif
  endfunction

  logic fwd_en;
  assign fwd_en = bus.we && !rst;

  assign bus.rdata_a = read_port(bus.raddr_a, fwd_en, bus.waddr, bus.wdata, regs[bus.raddr_a]);
  assign bus.rdata_b = read_port(bus.raddr_b, fwd_en, bus.waddr, bus.wdata, regs[bus.raddr_b]);
  assign bus.rdata_c = read_port(bus.raddr_c, fwd_en, bus.waddr, bus.wdata, regs[bus.raddr_c]);

  logic [SHW-1:0]    sh;
  logic [DWIDTH:0]   sum;
  logic [DWIDTH:0]   diff;
  logic [DWIDTH:0]   shl;
  logic [DWIDTH:0]   shr;
  logic [DWIDTH-1:0] res;
  logic              c_flag;
  logic              v_flag;

  assign sh   = bus.alu_b[SHW-1:0];
  assign sum  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign diff = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
  // One guard bit on the outgoing side captures the last bit shifted out; it stays 0 for a zero shift.
  assign shl  = {1'b0, bus.alu_a} << sh;
  assign shr  = {bus.alu_a, 1'b0} >> sh;

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (alu_op_e'(bus.alu_op))
      OP_ADD: begin
        res    = sum[DWIDTH-1:0];
        c_flag = sum[DWIDTH];
        v_flag = (bus.alu_a[DWIDTH-1] == bus.alu_b[DWIDTH-1]) &&
                 (res[DWIDTH-1] != bus.alu_a[DWIDTH-1]);
      end
      OP_SUB: begin
        res    = diff[DWIDTH-1:0];
        c_flag = ~diff[DWIDTH];
        v_flag = (bus.alu_a[DWIDTH-1] != bus.alu_b[DWIDTH-1]) &&
                 (res[DWIDTH-1] != bus.alu_a[DWIDTH-1]);
      end
      OP_AND: res = bus.alu_a & bus.alu_b;
      OP_OR:  res = bus.alu_a | bus.alu_b;
      OP_XOR: res = bus.alu_a ^ bus.alu_b;
      OP_LSL: begin
        res    = shl[DWIDTH-1:0];
        c_flag = shl[DWIDTH];
      end
      OP_LSR: begin
        res    = shr[DWIDTH:1];
        c_flag = shr[0];
      end
      OP_MOV: res = bus.alu_b;
      default: begin
        res    = 'x;
        c_flag = 1'bx;
        v_flag = 1'bx;
      end
    endcase
  end

  assign bus.alu_result = res;
  assign bus.alu_cc     = {res[DWIDTH-1], (res == '0), c_flag, v_flag};

endmodule

// File: tb/tb_alu_regfile.sv
// Scoreboard bench for alu_regfile: directed vectors then random traffic against an arithmetic reference model.
module tb_alu_regfile;
  logic clk;
  logic rst;

  alu_regfile_if #(.DWIDTH(16), .AWIDTH(3)) bus ();

  alu_regfile #(.DWIDTH(16), .AWIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk_rd;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rc;
    logic [15:0] res;
    logic [3:0]  cc;
  } exp_t;

  exp_t        q[$];
  logic        chk_vld;
  int          checks;
  int          errors;
  logic [15:0] model_regs [8];

  // Reference ALU computed from integer arithmetic on the operand values.
  task automatic alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic [3:0] cc);
    int ua, ub, sa, sb, full, sh;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = ub % 16;
    c = 1'b0;
    v = 1'b0;
    full = 0;
    case (op)
      3'd0: begin full = ua + ub; c = (full > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      3'd1: begin full = ua - ub; c = (ua >= ub);     v = (sa - sb > 32767) || (sa - sb < -32768); end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ua ^ ub;
      3'd5: begin full = ua << sh; c = (sh != 0) && (((ua >> (16 - sh)) & 1) == 1); end
      3'd6: begin full = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      default: full = ub;
    endcase
    r  = full[15:0];
    cc = {r[15], (r == 16'd0), c, v};
  endtask

  function automatic logic [15:0] read_model(input logic [2:0] addr, input logic r, input logic w,
                                             input logic [2:0] wa, input logic [15:0] wd);
`ifdef REGFILE_BYPASS_EN
    if (w && !r && wa == addr) return wd;
`endif
    return model_regs[addr];
  endfunction

  task automatic step(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                      input logic [2:0] pa, input logic [2:0] pb, input logic [2:0] pc,
                      input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                      input logic chkrd, input logic use_k, input logic [15:0] kres, input logic [3:0] kcc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.we = w; bus.waddr = wa; bus.wdata = wd;
    bus.raddr_a = pa; bus.raddr_b = pb; bus.raddr_c = pc;
    bus.alu_op = op; bus.alu_a = x; bus.alu_b = y;
    e.chk_rd = chkrd;
    e.ra = read_model(pa, r, w, wa, wd);
    e.rb = read_model(pb, r, w, wa, wd);
    e.rc = read_model(pc, r, w, wa, wd);
    if (use_k) begin
      e.res = kres;
      e.cc  = kcc;
    end else begin
      alu_model(op, x, y, e.res, e.cc);
    end
    q.push_back(e);
    chk_vld = 1'b1;
    if (r) begin
      for (int i = 0; i < 8; i++) model_regs[i] = 16'd0;
    end else if (w) begin
      model_regs[wa] = wd;
    end
  endtask

  task automatic rf(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                    input logic [2:0] pa, input logic [2:0] pb, input logic [2:0] pc);
    step(r, w, wa, wd, pa, pb, pc, 3'd0, 16'd0, 16'd0, 1'b1, 1'b1, 16'd0, 4'b0100);
  endtask

  task automatic alu_k(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] kres, input logic [3:0] kcc);
    step(1'b0, 1'b0, 3'd0, 16'd0, 3'd0, 3'd1, 3'd2, op, x, y, 1'b1, 1'b1, kres, kcc);
  endtask

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_vld) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp("alu_result", bus.alu_result, e.res);
        cmp("alu_cc", {12'd0, bus.alu_cc}, {12'd0, e.cc});
        if (e.chk_rd) begin
          cmp("rdata_a", bus.rdata_a, e.ra);
          cmp("rdata_b", bus.rdata_b, e.rb);
          cmp("rdata_c", bus.rdata_c, e.rc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish within 500000 time units");
    $fatal(1, "timeout");
  end

  logic [15:0] corner [5];

  initial begin
    checks = 0;
    errors = 0;
    chk_vld = 1'b0;
    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.raddr_a = '0; bus.raddr_b = '0; bus.raddr_c = '0;
    bus.alu_op = '0; bus.alu_a = '0; bus.alu_b = '0;
    for (int i = 0; i < 8; i++) model_regs[i] = 16'd0;
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'hFFFF;

    // Reset with a competing write to r3, then every register must read zero.
    step(1'b1, 1'b1, 3'd3, 16'h1234, 3'd3, 3'd0, 3'd1, 3'd0, 16'd0, 16'd0, 1'b0, 1'b1, 16'd0, 4'b0100);
    rf(1'b0, 1'b0, 3'd0, 16'd0, 3'd0, 3'd1, 3'd2);
    rf(1'b0, 1'b0, 3'd0, 16'd0, 3'd3, 3'd4, 3'd5);
    rf(1'b0, 1'b0, 3'd0, 16'd0, 3'd6, 3'd7, 3'd3);

    for (int i = 0; i < 8; i++) rf(1'b0, 1'b1, 3'(i), 16'h1000 + 16'(i), 3'd0, 3'd1, 3'd2);
    rf(1'b0, 1'b0, 3'd0, 16'd0, 3'd2, 3'd5, 3'd7);

    // Same-cycle read of the address being written.
    rf(1'b0, 1'b1, 3'd4, 16'h0001, 3'd0, 3'd0, 3'd0);
    rf(1'b0, 1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd4, 3'd1);
    rf(1'b0, 1'b0, 3'd0, 16'd0, 3'd4, 3'd3, 3'd4);

    alu_k(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
    alu_k(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110);
    alu_k(3'd1, 16'd5,    16'd5,    16'h0000, 4'b0110);
    alu_k(3'd1, 16'd3,    16'd5,    16'hFFFE, 4'b1000);
    alu_k(3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
    alu_k(3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
    alu_k(3'd5, 16'h8001, 16'h0001, 16'h0002, 4'b0010);
    alu_k(3'd6, 16'h0001, 16'h0001, 16'h0000, 4'b0110);
    alu_k(3'd7, 16'h0000, 16'hFFF8, 16'hFFF8, 4'b1000);
    alu_k(3'd5, 16'hABCD, 16'h0010, 16'hABCD, 4'b1000);

    // Mid-sequence reset clears everything on that edge.
    rf(1'b1, 1'b1, 3'd2, 16'h5555, 3'd2, 3'd4, 3'd7);
    rf(1'b0, 1'b0, 3'd0, 16'd0, 3'd2, 3'd4, 3'd7);

    for (int n = 0; n < 1500; n++) begin
      logic [15:0] x, y;
      x = ($urandom % 3 == 0) ? corner[$urandom % 5] : 16'($urandom);
      y = ($urandom % 3 == 0) ? corner[$urandom % 5] : 16'($urandom);
      step(($urandom % 60) == 0, 1'($urandom), 3'($urandom), 16'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), x, y,
           1'b1, 1'b0, 16'd0, 4'd0);
    end

    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
